// File: rtl/burst_read_arbiter.sv
// burst_read_arbiter: round-robin sharing of one AR/R channel pair
// between two burst request streams, with in-order R beat steering.
module burst_read_arbiter #(
  parameter int AddrWidth      = 64,
  parameter int BurstLenWidth  = 8,
  parameter int DataWidth      = 512,
  parameter int OutstandingLog = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BurstLenWidth+AddrWidth-1:0] req0_dout,
  input  logic                             req0_empty_n,
  output logic                             req0_read,
  input  logic [BurstLenWidth+AddrWidth-1:0] req1_dout,
  input  logic                             req1_empty_n,
  output logic                             req1_read,
  output logic [AddrWidth-1:0]             ar_addr,
  output logic [BurstLenWidth-1:0]         ar_len,
  output logic                             ar_valid,
  input  logic                             ar_ready,
  input  logic [DataWidth-1:0]             r_data,
  input  logic                             r_last,
  input  logic                             r_valid,
  output logic                             r_ready,
  output logic [DataWidth-1:0]             resp0_din,
  input  logic                             resp0_full_n,
  output logic                             resp0_write,
  output logic [DataWidth-1:0]             resp1_din,
  input  logic                             resp1_full_n,
  output logic                             resp1_write
);

  localparam int MaxOut = 1 << OutstandingLog;

  logic [MaxOut-1:0]         order_q;
  logic [OutstandingLog-1:0] wr_ptr;
  logic [OutstandingLog-1:0] rd_ptr;
  logic [OutstandingLog:0]   occ;
  logic                      last_grant;

  logic slot_free;
  logic can_grant;
  logic gnt0;
  logic gnt1;
  logic push;
  logic head;
  logic beat;
  logic pop;
  logic [BurstLenWidth+AddrWidth-1:0] gnt_dout;

  // occ never exceeds MaxOut, so its MSB alone flags a full order FIFO
  assign slot_free = !ar_valid || ar_ready;
  assign can_grant = !rst && slot_free && !occ[OutstandingLog];

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (can_grant) begin
      unique case (1'b1)
        req0_empty_n && req1_empty_n: begin
          gnt0 = last_grant;
          gnt1 = !last_grant;
        end
        req0_empty_n && !req1_empty_n: gnt0 = 1'b1;
        !req0_empty_n && req1_empty_n: gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign req0_read = gnt0;
  assign req1_read = gnt1;
  assign push      = gnt0 || gnt1;
  assign gnt_dout  = gnt1 ? req1_dout : req0_dout;

  assign head    = order_q[rd_ptr];
  assign r_ready = (occ != '0) && (head ? resp1_full_n : resp0_full_n);
  assign beat    = r_valid && r_ready;
  assign pop     = beat && r_last;

  assign resp0_write = beat && !head;
  assign resp1_write = beat && head;
  assign resp0_din   = r_data;
  assign resp1_din   = r_data;

  always_ff @(posedge clk) begin
    if (push) order_q[wr_ptr] <= gnt1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_valid   <= 1'b0;
      ar_addr    <= '0;
      ar_len     <= '0;
      last_grant <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
    end else begin
      if (push) begin
        ar_valid   <= 1'b1;
        ar_addr    <= gnt_dout[AddrWidth-1:0];
        ar_len     <= gnt_dout[BurstLenWidth+AddrWidth-1:AddrWidth];
        last_grant <= gnt1;
        wr_ptr     <= wr_ptr + 1'b1;
      end else if (ar_ready) begin
        ar_valid <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_read_arbiter.sv
// Scoreboard bench for burst_read_arbiter: AR and R-route
// expectations are queued at grant time and popped on DUT output.
module tb_burst_read_arbiter;

  localparam int AW = 64;
  localparam int LW = 8;
  localparam int DW = 64;
  localparam int OL = 2;

  logic clk = 1'b0;
  logic rst;
  logic [LW+AW-1:0] req0_dout;
  logic [LW+AW-1:0] req1_dout;
  logic req0_empty_n;
  logic req1_empty_n;
  logic req0_read;
  logic req1_read;
  logic [AW-1:0] ar_addr;
  logic [LW-1:0] ar_len;
  logic ar_valid;
  logic ar_ready;
  logic [DW-1:0] r_data;
  logic r_last;
  logic r_valid;
  logic r_ready;
  logic [DW-1:0] resp0_din;
  logic [DW-1:0] resp1_din;
  logic resp0_full_n;
  logic resp1_full_n;
  logic resp0_write;
  logic resp1_write;

  int checks = 0;
  int failures = 0;
  logic [LW+AW-1:0] ar_q[$];
  bit port_q[$];
  bit tb_last;

  burst_read_arbiter #(
    .AddrWidth(AW),
    .BurstLenWidth(LW),
    .DataWidth(DW),
    .OutstandingLog(OL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req0_dout(req0_dout),
    .req0_empty_n(req0_empty_n),
    .req0_read(req0_read),
    .req1_dout(req1_dout),
    .req1_empty_n(req1_empty_n),
    .req1_read(req1_read),
    .ar_addr(ar_addr),
    .ar_len(ar_len),
    .ar_valid(ar_valid),
    .ar_ready(ar_ready),
    .r_data(r_data),
    .r_last(r_last),
    .r_valid(r_valid),
    .r_ready(r_ready),
    .resp0_din(resp0_din),
    .resp0_full_n(resp0_full_n),
    .resp0_write(resp0_write),
    .resp1_din(resp1_din),
    .resp1_full_n(resp1_full_n),
    .resp1_write(resp1_write)
  );

  always #5 clk = ~clk;

  task automatic idle();
    req0_dout = '0;
    req1_dout = '0;
    req0_empty_n = 1'b0;
    req1_empty_n = 1'b0;
    ar_ready = 1'b1;
    r_data = '0;
    r_last = 1'b0;
    r_valid = 1'b0;
    resp0_full_n = 1'b1;
    resp1_full_n = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tb_last = 1'b1;
    ar_q.delete();
    port_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    req0_empty_n = 1'b1;
    req1_empty_n = 1'b1;
    #1;
    checks++;
    if ({req0_read, req1_read} !== 2'b00) begin
      failures++;
      $display("FAIL reset_req_read got=%b want=00", {req0_read, req1_read});
    end
    @(negedge clk);
    rst = 1'b0;
    req0_empty_n = 1'b0;
    req1_empty_n = 1'b0;
    r_valid = 1'b1;
    tb_last = 1'b1;
    #1;
    checks++;
    if ({ar_valid, ar_addr, ar_len} !== '0) begin
      failures++;
      $display("FAIL reset_ar got=%b/%h/%h want=0/0/0", ar_valid, ar_addr, ar_len);
    end
    checks++;
    if ({r_ready, resp0_write, resp1_write} !== 3'b000) begin
      failures++;
      $display("FAIL reset_r got=%b want=000", {r_ready, resp0_write, resp1_write});
    end
    r_valid = 1'b0;
  endtask

  task automatic test_single();
    logic [LW+AW-1:0] exp;
    logic [DW-1:0] d;
    bit p;
    pulse_reset();
    req0_dout = {8'd3, 64'h1000};
    req0_empty_n = 1'b1;
    #1;
    checks++;
    if ({req0_read, req1_read} !== 2'b10) begin
      failures++;
      $display("FAIL single_grant got=%b want=10", {req0_read, req1_read});
    end
    ar_q.push_back(req0_dout);
    port_q.push_back(1'b0);
    @(negedge clk);
    req0_empty_n = 1'b0;
    #1;
    exp = ar_q.pop_front();
    checks++;
    if (req0_read !== 1'b0 || ar_valid !== 1'b1 || {ar_len, ar_addr} !== exp) begin
      failures++;
      $display("FAIL single_ar got=%b/%b/%h want=0/1/%h",
               req0_read, ar_valid, {ar_len, ar_addr}, exp);
    end
    p = port_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d = {$urandom, $urandom};
      r_data = d;
      r_valid = 1'b1;
      r_last = (i == 3);
      #1;
      checks++;
      if (resp0_write !== !p || resp1_write !== p || resp0_din !== d) begin
        failures++;
        $display("FAIL single_beat%0d got=%b%b/%h want=%b%b/%h",
                 i, resp0_write, resp1_write, resp0_din, !p, p, d);
      end
    end
    @(negedge clk);
    r_last = 1'b0;
    #1;
    checks++;
    if (r_ready !== 1'b0 || ar_valid !== 1'b0 || resp0_write !== 1'b0) begin
      failures++;
      $display("FAIL single_drained got=%b/%b/%b want=0/0/0",
               r_ready, ar_valid, resp0_write);
    end
    r_valid = 1'b0;
  endtask

  task automatic test_contention();
    logic [LW+AW-1:0] exp;
    bit p;
    pulse_reset();
    req0_empty_n = 1'b1;
    req1_empty_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        req0_empty_n = 1'b0;
        req1_empty_n = 1'b0;
      end
      req0_dout = {8'd1, 64'hA000 + 64'(i * 'h40)};
      req1_dout = {8'd1, 64'hB000 + 64'(i * 'h40)};
      #1;
      if (i > 0) begin
        exp = ar_q.pop_front();
        checks++;
        if (ar_valid !== 1'b1 || {ar_len, ar_addr} !== exp) begin
          failures++;
          $display("FAIL contention_ar%0d got=%b/%h want=1/%h",
                   i, ar_valid, {ar_len, ar_addr}, exp);
        end
      end
      if (i < 4) begin
        p = !tb_last;
        checks++;
        if (req0_read !== !p || req1_read !== p) begin
          failures++;
          $display("FAIL contention_grant%0d got=%b%b want=%b%b",
                   i, req0_read, req1_read, !p, p);
        end
        ar_q.push_back(p ? req1_dout : req0_dout);
        port_q.push_back(p);
        tb_last = p;
      end
      @(negedge clk);
    end
    while (port_q.size() > 0) begin
      p = port_q.pop_front();
      for (int b = 0; b < 2; b++) begin
        r_valid = 1'b1;
        r_last = (b == 1);
        r_data = {$urandom, $urandom};
        #1;
        checks++;
        if (resp0_write !== !p || resp1_write !== p) begin
          failures++;
          $display("FAIL contention_route got=%b%b want=%b%b",
                   resp0_write, resp1_write, !p, p);
        end
        @(negedge clk);
      end
    end
    r_valid = 1'b0;
    r_last = 1'b0;
  endtask

  task automatic test_ar_backpressure();
    logic [LW+AW-1:0] exp;
    pulse_reset();
    ar_ready = 1'b0;
    req0_empty_n = 1'b1;
    req0_dout = {8'd7, 64'h2000};
    #1;
    checks++;
    if (req0_read !== 1'b1) begin
      failures++;
      $display("FAIL bp_first_grant got=%b want=1", req0_read);
    end
    ar_q.push_back(req0_dout);
    exp = req0_dout;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req0_dout = {8'd9, 64'h3000};
      #1;
      checks++;
      if (req0_read !== 1'b0 || ar_valid !== 1'b1 || {ar_len, ar_addr} !== exp) begin
        failures++;
        $display("FAIL bp_hold%0d got=%b/%b/%h want=0/1/%h",
                 i, req0_read, ar_valid, {ar_len, ar_addr}, exp);
      end
    end
    @(negedge clk);
    ar_ready = 1'b1;
    #1;
    checks++;
    if (req0_read !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_grant got=%b want=1", req0_read);
    end
    void'(ar_q.pop_front());
    ar_q.push_back(req0_dout);
    @(negedge clk);
    req0_empty_n = 1'b0;
    #1;
    exp = ar_q.pop_front();
    checks++;
    if (ar_valid !== 1'b1 || {ar_len, ar_addr} !== exp) begin
      failures++;
      $display("FAIL bp_second_ar got=%b/%h want=1/%h",
               ar_valid, {ar_len, ar_addr}, exp);
    end
  endtask

  task automatic test_outstanding();
    logic [LW+AW-1:0] exp;
    pulse_reset();
    req0_empty_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_dout = {8'd0, 64'h4000 + 64'(i * 'h40)};
      #1;
      checks++;
      if (req0_read !== (i < 4)) begin
        failures++;
        $display("FAIL limit_grant%0d got=%b want=%b", i, req0_read, i < 4);
      end
      if (i < 4) ar_q.push_back(req0_dout);
      @(negedge clk);
    end
    ar_q.delete();
    r_valid = 1'b1;
    r_last = 1'b1;
    req0_dout = {8'd0, 64'h5000};
    #1;
    checks++;
    if (resp0_write !== 1'b1 || req0_read !== 1'b0) begin
      failures++;
      $display("FAIL limit_pop_cycle got=%b/%b want=1/0", resp0_write, req0_read);
    end
    @(negedge clk);
    r_valid = 1'b0;
    r_last = 1'b0;
    #1;
    checks++;
    if (req0_read !== 1'b1) begin
      failures++;
      $display("FAIL limit_regrant got=%b want=1", req0_read);
    end
    ar_q.push_back(req0_dout);
    @(negedge clk);
    req0_empty_n = 1'b0;
    #1;
    exp = ar_q.pop_front();
    checks++;
    if (ar_valid !== 1'b1 || {ar_len, ar_addr} !== exp) begin
      failures++;
      $display("FAIL limit_fifth_ar got=%b/%h want=1/%h",
               ar_valid, {ar_len, ar_addr}, exp);
    end
  endtask

  task automatic test_resp_backpressure();
    logic [DW-1:0] d;
    pulse_reset();
    req1_empty_n = 1'b1;
    req1_dout = {8'd0, 64'h6000};
    #1;
    checks++;
    if ({req0_read, req1_read} !== 2'b01) begin
      failures++;
      $display("FAIL rbp_grant got=%b want=01", {req0_read, req1_read});
    end
    @(negedge clk);
    req1_empty_n = 1'b0;
    d = {$urandom, $urandom};
    r_data = d;
    r_valid = 1'b1;
    r_last = 1'b1;
    resp1_full_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({r_ready, resp0_write, resp1_write} !== 3'b000) begin
        failures++;
        $display("FAIL rbp_stall%0d got=%b want=000",
                 i, {r_ready, resp0_write, resp1_write});
      end
      @(negedge clk);
    end
    resp1_full_n = 1'b1;
    #1;
    checks++;
    if ({r_ready, resp0_write, resp1_write} !== 3'b101 || resp1_din !== d) begin
      failures++;
      $display("FAIL rbp_release got=%b/%h want=101/%h",
               {r_ready, resp0_write, resp1_write}, resp1_din, d);
    end
    @(negedge clk);
    r_valid = 1'b0;
    r_last = 1'b0;
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    req0_empty_n = 1'b1;
    req1_empty_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({req0_read, req1_read} !== 2'b00) begin
      failures++;
      $display("FAIL midrst_read got=%b want=00", {req0_read, req1_read});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ar_valid !== 1'b0 || r_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_state got=%b/%b want=0/0", ar_valid, r_ready);
    end
    checks++;
    if ({req0_read, req1_read} !== 2'b10) begin
      failures++;
      $display("FAIL midrst_first_win got=%b want=10", {req0_read, req1_read});
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tb_last = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_ar_backpressure();
    test_outstanding();
    test_resp_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/burst_read_arbiter.md
# burst_read_arbiter

Two-port round-robin arbiter that shares one memory read-address/read-data channel pair between two burst-detected request streams. Each request is a packed {burst_len, base_addr} word as produced by the burst-detection stage. The arbiter issues bursts on a single AR-style channel and tracks them in an in-order grant FIFO. Returning read beats are steered back to the requester that owns each burst. It sits between two burst detectors and the memory-side read port.

## Interface
- AddrWidth, 64, byte address width.
- BurstLenWidth, 8, burst length field width; value N means N+1 beats.
- DataWidth, 512, read data width.
- OutstandingLog, 4, log2 of the maximum number of outstanding bursts (MaxOutstanding = 2^OutstandingLog).
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req0_dout  in  BurstLenWidth+AddrWidth  port-0 request, {len, addr}.
- req0_empty_n  in  1  port-0 request valid.
- req0_read  out  1  port-0 request pop.
- req1_dout, req1_empty_n, req1_read  same as port 0, for port 1.
- ar_addr  out  AddrWidth  burst address.
- ar_len  out  BurstLenWidth  burst length (beats-1).
- ar_valid  out  1  address valid.
- ar_ready  in  1  address accepted.
- r_data  in  DataWidth  read beat.
- r_last  in  1  last beat of burst.
- r_valid  in  1  beat valid.
- r_ready  out  1  beat accepted.
- resp0_din  out  DataWidth  port-0 data.
- resp0_full_n  in  1  port-0 sink not full.
- resp0_write  out  1  port-0 push.
- resp1_din, resp1_full_n, resp1_write  same as port 0, for port 1.

## Operation
- **State:**
  - AR output register (ar_addr, ar_len, ar_valid).
  - last_grant bit.
  - Order FIFO of port IDs, depth MaxOutstanding, with occupancy counter of width OutstandingLog+1.
- **AR slot free:** the slot is free when ar_valid==0, or when ar_valid && ar_ready in the current cycle.
- **Grant condition:** AR slot free AND occupancy < MaxOutstanding AND at least one reqN_empty_n is high.
- **Round robin:**
  - If both ports request, grant the port != last_grant.
  - If one port requests, grant that port.
  - last_grant updates to the granted port.
- **On grant:**
  - Assert reqN_read combinationally in the same cycle.
  - Next cycle: ar_addr = dout[AddrWidth-1:0], ar_len = dout[BurstLenWidth+AddrWidth-1:AddrWidth], ar_valid = 1.
  - Push the granted port ID into the order FIFO in the same cycle as the grant.
- **No grant:** if ar_valid && ar_ready and no grant occurs, ar_valid clears. ar_addr and ar_len hold their values.
- **ar_valid is sticky:** once asserted, ar_valid never drops without ar_ready.
- **R path:**
  - head = order FIFO head port ID.
  - r_ready = FIFO non-empty && resp[head]_full_n.
  - resp[head]_write = r_valid && r_ready.
  - resp0_din = resp1_din = r_data (combinational).
  - The other port's write stays 0.
- **Pop:** the order FIFO pops on r_valid && r_ready && r_last.
- **Simultaneous push and pop:** occupancy is unchanged and both operations take effect.
- **Empty order FIFO:** if r_valid arrives while the FIFO is empty, r_ready = 0 and beats are not consumed. This is a protocol error and the arbiter stalls.
- **Occupancy at limit:** at occupancy == MaxOutstanding there is no grant. A pop in the same cycle does not enable a grant until the next cycle (grant uses the registered occupancy).

## Timing
- **Reset values:**
  - ar_valid = 0, ar_addr = 0, ar_len = 0.
  - req0_read = req1_read = 0 (combinational; also 0 whenever rst is high).
  - r_ready = 0, resp0_write = resp1_write = 0.
  - Order FIFO empty, occupancy 0.
  - last_grant = 1, so port 0 wins the first contention.
- **Request to AR:** 1 cycle from reqN_read to ar_valid.
- **Back-to-back:** one grant per cycle sustained while ar_ready stays high.
- **R path latency:** combinational, 0 cycles from r_valid to respN_write.
- **Reset mid-operation:** all outstanding tracking is discarded. In-flight beats after reset are handled by the empty-FIFO rule above.
- **Sticky valid:** ar_addr and ar_len are stable while ar_valid && !ar_ready.

## Test plan
- **Single request:** port 0 only, dout = {8'd3, 64'h1000}, ar_ready = 1 → req0_read pulses once; next cycle ar_valid = 1, ar_addr = 0x1000, ar_len = 3. Then 4 R beats with r_last on the 4th → 4 resp0_write pulses, no resp1_write, occupancy returns to 0.
- **Contention:** both ports always non-empty, ar_ready = 1 → grants alternate 0,1,0,1 starting with port 0. R beats route in grant order.
- **Backpressure on AR:** ar_ready = 0 for 5 cycles with ar_valid = 1 → ar_addr and ar_len stable, no further reqN_read. On ar_ready = 1, a new grant occurs in that same cycle.
- **Outstanding limit:** with OutstandingLog = 2, issue 4 bursts with no R traffic → the 5th request is not read. One r_last beat → the 5th grant occurs the following cycle.
- **Response backpressure:** head = port 1, resp1_full_n = 0, r_valid = 1 → r_ready = 0 and no writes. When resp1_full_n rises, the beat is written to port 1 the same cycle.
- **Reset mid-burst:** assert rst with 2 bursts outstanding → next cycle ar_valid = 0, occupancy 0, r_ready = 0, and the next contention is won by port 0.
